// File: rtl/dmem_pkg.sv
// Shared definitions for the data-cache <-> data-memory block interface.
// Width defaults are shared with the cache side; the state encoding is used
// by the block memory controller.
package dmem_pkg;

    localparam int DMEM_ADDR_W  = 28;
    localparam int DMEM_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_block_array.sv
// Block storage for the data memory: one synchronous write port and one
// asynchronous read port sharing a single index. Contents are not reset.
module dmem_block_array #(
    parameter int DEPTH   = 256,
    parameter int BLOCK_W = 128,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               write_en,
    input  logic [IDX_W-1:0]   address,
    input  logic [BLOCK_W-1:0] write_data,
    output logic [BLOCK_W-1:0] read_data
);

    logic [BLOCK_W-1:0] blocks [DEPTH];

    // Commit a block on the clock edge when the controller enables a write
    always_ff @(posedge clock) begin
        if (write_en) begin
            blocks[address] <= write_data;
        end
    end

    assign read_data = blocks[address];

endmodule

// File: rtl/block_data_memory.sv
// Slow main-memory model serving 128-bit block refills and write-backs for
// the data cache. A request is latched in IDLE, serviced for LATENCY edges in
// BUSY, and acknowledged by one cycle of busywait low in DONE.
module block_data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int BLOCK_W = DMEM_BLOCK_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [ADDR_W-1:0]  mem_address,
    input  logic [BLOCK_W-1:0] mem_writedata,
    output logic [BLOCK_W-1:0] mem_readdata,
    output logic               mem_busywait
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    dmem_state_t        state;
    logic [CNT_W-1:0]   counter;
    logic [IDX_W-1:0]   idx_q;
    logic [BLOCK_W-1:0] wdata_q;
    logic               write_q;
    logic [BLOCK_W-1:0] array_rdata;
    logic               finish;
    logic               array_we;

    // Upper address bits alias silently onto the same storage index
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_address[ADDR_W-1:IDX_W];

    assign finish   = (state == BUSY) && (counter == CNT_W'(LATENCY));
    assign array_we = finish && write_q && !reset;

    // Busywait rises combinationally in IDLE so the requester never sees a gap
    assign mem_busywait = !reset &&
                          ((state == BUSY) ||
                           ((state == IDLE) && (mem_read || mem_write)));

    dmem_block_array #(
        .DEPTH   (DEPTH),
        .BLOCK_W (BLOCK_W),
        .IDX_W   (IDX_W)
    ) u_array (
        .clock      (clock),
        .write_en   (array_we),
        .address    (idx_q),
        .write_data (wdata_q),
        .read_data  (array_rdata)
    );

    // Transaction FSM: latch request, count out the latency, complete, acknowledge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            mem_readdata <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        idx_q   <= mem_address[IDX_W-1:0];
                        wdata_q <= mem_writedata;
                        write_q <= mem_write;
                        counter <= CNT_W'(1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        if (!write_q) begin
                            mem_readdata <= array_rdata;
                        end
                        counter <= '0;
                        state   <= DONE;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    counter <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: a table of single transactions with
// hand-computed results, followed by back-to-back, reset-abort and
// changed-inputs sequences.
module tb_block_data_memory;

    localparam int LATENCY = 5;
    localparam int NVEC    = 10;

    localparam logic [127:0] D1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] PA5  = 128'hA5A5_A5A5_5A5A_5A5A_A5A5_A5A5_5A5A_5A5A;
    localparam logic [127:0] P1   = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] PDE  = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
    localparam logic [127:0] DA   = 128'h0A0A_0A0A_1B1B_1B1B_2C2C_2C2C_3D3D_3D3D;
    localparam logic [127:0] DB   = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;

    logic         clock;
    logic         reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int vectors;
    int miscompares;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_rdata;
    } vec_t;

    vec_t vecs [NVEC];

    block_data_memory #(
        .ADDR_W  (28),
        .BLOCK_W (128),
        .DEPTH   (256),
        .LATENCY (LATENCY)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a negedge with the FSM in IDLE
    task automatic apply_stimulus(input logic rd, input logic wr,
                                  input logic [27:0] addr, input logic [127:0] data);
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = addr;
        mem_writedata = data;
    endtask

    // Counts rising edges until busywait is seen low at a negedge (bounded)
    task automatic wait_done(output int edges);
        edges = 0;
        do begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end while (mem_busywait && edges < 50);
    endtask

    // Drop the request during DONE and step into IDLE
    task automatic release_request(input string name);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_output({name, "_idle_busy"}, 128'(mem_busywait), 128'(0));
    endtask

    initial begin
        int edges;
        vectors     = 0;
        miscompares = 0;

        vecs[0] = '{1'b0, 1'b1, 28'h0000012, D1,   128'h0};
        vecs[1] = '{1'b1, 1'b0, 28'h0000012, '0,   D1};
        vecs[2] = '{1'b1, 1'b1, 28'h0000020, ONES, D1};
        vecs[3] = '{1'b1, 1'b0, 28'h0000020, '0,   ONES};
        vecs[4] = '{1'b0, 1'b1, 28'h0000030, PA5,  ONES};
        vecs[5] = '{1'b1, 1'b0, 28'h0000130, '0,   PA5};
        vecs[6] = '{1'b0, 1'b1, 28'h00000FF, P1,   PA5};
        vecs[7] = '{1'b1, 1'b0, 28'hFFFFFFF, '0,   P1};
        vecs[8] = '{1'b0, 1'b1, 28'h0000000, PDE,  P1};
        vecs[9] = '{1'b1, 1'b0, 28'h0000100, '0,   PDE};

        reset         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;

        // Asynchronous reset asserted mid-cycle
        #2 reset = 1'b1;
        #1;
        check_output("reset_busy", 128'(mem_busywait), 128'(0));
        check_output("reset_rdata", mem_readdata, 128'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_output("idle_busy", 128'(mem_busywait), 128'(0));
        check_output("idle_rdata", mem_readdata, 128'h0);

        // Table of single transactions
        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #1;
            check_output($sformatf("vec%0d_busy_now", i), 128'(mem_busywait), 128'(1));
            wait_done(edges);
            check_output($sformatf("vec%0d_latency", i), 128'(edges), 128'(LATENCY + 1));
            check_output($sformatf("vec%0d_rdata", i), mem_readdata, vecs[i].exp_rdata);
            release_request($sformatf("vec%0d", i));
        end

        // Asynchronous reset while idle with readdata non-zero
        #2 reset = 1'b1;
        #1;
        check_output("reset2_rdata", mem_readdata, 128'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Write-back then refill at an aliased address
        apply_stimulus(1'b0, 1'b1, 28'h0000005, DA);
        wait_done(edges);
        check_output("wb_latency", 128'(edges), 128'(LATENCY + 1));
        apply_stimulus(1'b1, 1'b0, 28'h0000105, '0);
        wait_done(edges);
        check_output("refill_spacing", 128'(edges), 128'(LATENCY + 2));
        check_output("refill_rdata", mem_readdata, DA);
        release_request("refill");

        // Reset during BUSY aborts a write
        apply_stimulus(1'b0, 1'b1, 28'h0000030, DB);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset     = 1'b1;
        mem_write = 1'b0;
        #1;
        check_output("abort_busy", 128'(mem_busywait), 128'(0));
        check_output("abort_rdata", mem_readdata, 128'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        apply_stimulus(1'b1, 1'b0, 28'h0000030, '0);
        wait_done(edges);
        check_output("abort_read_latency", 128'(edges), 128'(LATENCY + 1));
        check_output("abort_read_rdata", mem_readdata, PA5);
        release_request("abort_read");

        // Request dropped and address changed mid-BUSY
        apply_stimulus(1'b1, 1'b0, 28'h0000012, '0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("drop_busy_mid", 128'(mem_busywait), 128'(1));
        mem_address = 28'h0000040;
        mem_read    = 1'b0;
        wait_done(edges);
        check_output("drop_latency", 128'(edges + 3), 128'(LATENCY + 1));
        check_output("drop_rdata", mem_readdata, D1);
        release_request("drop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
